// File: rtl/decode_ctrl_seq.sv
// Registered RV32IM decode stage with MUL/DIV sequencing.
// Latency: 1 cycle from accept to valid_e; MDU ops then hold off fetch for MUL_LAT/DIV_LAT cycles.
// Backpressure: instr_ready drops during stall_in, MDU busy, flush and reset; stall_in holds the e-stage in IDLE.
module decode_ctrl_seq #(
  parameter int M_EXT   = 1,
  parameter int MUL_LAT = 1,
  parameter int DIV_LAT = 33
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  input  logic        stall_in,
  input  logic        flush,
  output logic        valid_e,
  output logic        branch_e,
  output logic        jump_e,
  output logic        jalr_e,
  output logic        mem_write_e,
  output logic        alu_src_e,
  output logic        reg_write_e,
  output logic [1:0]  result_src_e,
  output logic [2:0]  imm_src_e,
  output logic [2:0]  alu_op_e,
  output logic        rs1_used_e,
  output logic        rs2_used_e,
  output logic        mul_en_e,
  output logic        div_en_e,
  output logic        illegal_e,
  output logic        mdu_busy,
  output logic        mdu_done
);

  // Busy counter is sized for the longer of the two MDU latencies.
  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               valid_q, valid_d;
  logic [18:0]        ctl_q, ctl_d;
  logic [18:0]        dec_ctl;
  logic               accept;

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic       funct3_msb;
  logic       unused_instr_bits;

  logic       d_branch, d_jump, d_jalr, d_mem_write, d_alu_src, d_reg_write;
  logic [1:0] d_result_src;
  logic [2:0] d_imm_src, d_alu_op;
  logic       d_rs1, d_rs2, d_mul, d_div, d_illegal;

  assign opcode            = instr[6:0];
  assign funct7            = instr[31:25];
  assign funct3_msb        = instr[14];
  // Register indices, immediates and funct3[1:0] are consumed by later stages.
  assign unused_instr_bits = ^{instr[24:15], instr[13:7]};

  assign mdu_busy    = (state_q == S_BUSY);
  // An op whose last cycle coincides with flush or reset is aborted, so no done pulse.
  assign mdu_done    = mdu_busy && (cnt_q == CNT_W'(1)) && !flush && !rst;
  assign instr_ready = !mdu_busy && !stall_in && !rst && !flush;
  assign accept      = instr_valid && instr_ready;

  // Instruction decode into e-stage control fields; unknown encodings raise illegal only.
  always_comb begin
    d_branch     = 1'b0;
    d_jump       = 1'b0;
    d_jalr       = 1'b0;
    d_mem_write  = 1'b0;
    d_alu_src    = 1'b0;
    d_reg_write  = 1'b0;
    d_result_src = 2'd0;
    d_imm_src    = 3'd0;
    d_alu_op     = 3'd0;
    d_rs1        = 1'b0;
    d_rs2        = 1'b0;
    d_mul        = 1'b0;
    d_div        = 1'b0;
    d_illegal    = 1'b0;
    case (opcode)
      7'd51: begin
        if (funct7 == 7'd0 || funct7 == 7'd32) begin
          d_reg_write = 1'b1;
          d_alu_op    = 3'd2;
          d_rs1       = 1'b1;
          d_rs2       = 1'b1;
        end else if (M_EXT != 0 && funct7 == 7'd1) begin
          if (funct3_msb) begin
            d_div    = 1'b1;
            d_alu_op = 3'd5;
          end else begin
            d_mul    = 1'b1;
            d_alu_op = 3'd4;
          end
          d_reg_write = 1'b1;
          d_rs1       = 1'b1;
          d_rs2       = 1'b1;
        end else begin
          d_illegal = 1'b1;
        end
      end
      7'd3: begin
        d_result_src = 2'd1;
        d_alu_src    = 1'b1;
        d_imm_src    = 3'd0;
        d_reg_write  = 1'b1;
        d_rs1        = 1'b1;
      end
      7'd19: begin
        d_alu_src   = 1'b1;
        d_imm_src   = 3'd0;
        d_reg_write = 1'b1;
        d_alu_op    = 3'd2;
        d_rs1       = 1'b1;
      end
      7'd35: begin
        d_mem_write = 1'b1;
        d_alu_src   = 1'b1;
        d_imm_src   = 3'd1;
        d_rs1       = 1'b1;
        d_rs2       = 1'b1;
      end
      7'd99: begin
        d_branch  = 1'b1;
        d_imm_src = 3'd2;
        d_alu_op  = 3'd1;
        d_rs1     = 1'b1;
        d_rs2     = 1'b1;
      end
      7'd103: begin
        d_jump       = 1'b1;
        d_jalr       = 1'b1;
        d_alu_src    = 1'b1;
        d_imm_src    = 3'd0;
        d_result_src = 2'd2;
        d_reg_write  = 1'b1;
        d_rs1        = 1'b1;
      end
      7'd111: begin
        d_jump       = 1'b1;
        d_imm_src    = 3'd3;
        d_result_src = 2'd2;
        d_reg_write  = 1'b1;
      end
      7'd23: begin
        d_imm_src    = 3'd4;
        d_result_src = 2'd3;
        d_reg_write  = 1'b1;
      end
      7'd55: begin
        d_alu_src   = 1'b1;
        d_imm_src   = 3'd4;
        d_alu_op    = 3'd3;
        d_reg_write = 1'b1;
      end
      default: d_illegal = 1'b1;
    endcase
  end

  assign dec_ctl = {d_branch, d_jump, d_jalr, d_mem_write, d_alu_src, d_reg_write,
                    d_result_src, d_imm_src, d_alu_op, d_rs1, d_rs2, d_mul, d_div, d_illegal};

  assign {branch_e, jump_e, jalr_e, mem_write_e, alu_src_e, reg_write_e,
          result_src_e, imm_src_e, alu_op_e, rs1_used_e, rs2_used_e,
          mul_en_e, div_en_e, illegal_e} = ctl_q;
  assign valid_e = valid_q;

  // MDU sequencer next state: load latency on an accepted MUL/DIV, count down regardless of stall.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept && (d_mul || d_div)) begin
            state_d = S_BUSY;
            cnt_d   = d_mul ? CNT_W'(MUL_LAT) : CNT_W'(DIV_LAT);
          end
        end
        S_BUSY: begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // E-stage next state: flush kills, accept loads, stall holds only while the MDU is idle.
  always_comb begin
    valid_d = 1'b0;
    ctl_d   = ctl_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      ctl_d   = dec_ctl;
    end else if (!mdu_busy && stall_in) begin
      valid_d = valid_q;
    end
  end

  // State, counter and pipeline register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      ctl_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      ctl_q   <= ctl_d;
    end
  end

endmodule

// File: tb/tb_decode_ctrl_seq.sv
// Testbench for decode_ctrl_seq: decode vector table, MDU timing/flush/stall sequences,
// M_EXT=0 instance, and a randomized run against a cycle-level reference model.
module tb_decode_ctrl_seq;

  typedef struct packed {
    logic       branch, jump, jalr, mem_write, alu_src, reg_write;
    logic [1:0] result_src;
    logic [2:0] imm_src;
    logic [2:0] alu_op;
    logic       rs1_used, rs2_used, mul_en, div_en, illegal;
  } ctrl_t;

  typedef struct {
    logic [31:0] instr;
    ctrl_t       exp;
  } vec_t;

  localparam logic [31:0] I_ADD = 32'h003100B3;
  localparam logic [31:0] I_MUL = 32'h023100B3;
  localparam logic [31:0] I_DIV = 32'h023140B3;
  localparam logic [31:0] I_BAD = 32'h0000007F;
  localparam int DLAT = 33;
  localparam int MLAT = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic [31:0] instr = 32'h0;
  logic        stall_in = 1'b0;
  logic        flush = 1'b0;

  logic       a_ready, a_valid, a_busy, a_done;
  logic       a_br, a_jp, a_jr, a_mw, a_as, a_rw, a_u1, a_u2, a_mu, a_dv, a_il;
  logic [1:0] a_rs;
  logic [2:0] a_is, a_ao;
  logic       b_ready, b_valid, b_busy, b_done;
  logic       b_br, b_jp, b_jr, b_mw, b_as, b_rw, b_u1, b_u2, b_mu, b_dv, b_il;
  logic [1:0] b_rs;
  logic [2:0] b_is, b_ao;
  ctrl_t      a_c, b_c;

  assign a_c = {a_br, a_jp, a_jr, a_mw, a_as, a_rw, a_rs, a_is, a_ao, a_u1, a_u2, a_mu, a_dv, a_il};
  assign b_c = {b_br, b_jp, b_jr, b_mw, b_as, b_rw, b_rs, b_is, b_ao, b_u1, b_u2, b_mu, b_dv, b_il};

  always #5 clk = ~clk;

  decode_ctrl_seq #(.M_EXT(1), .MUL_LAT(MLAT), .DIV_LAT(DLAT)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr), .instr_ready(a_ready),
    .stall_in(stall_in), .flush(flush), .valid_e(a_valid),
    .branch_e(a_br), .jump_e(a_jp), .jalr_e(a_jr), .mem_write_e(a_mw), .alu_src_e(a_as),
    .reg_write_e(a_rw), .result_src_e(a_rs), .imm_src_e(a_is), .alu_op_e(a_ao),
    .rs1_used_e(a_u1), .rs2_used_e(a_u2), .mul_en_e(a_mu), .div_en_e(a_dv),
    .illegal_e(a_il), .mdu_busy(a_busy), .mdu_done(a_done)
  );

  decode_ctrl_seq #(.M_EXT(0), .MUL_LAT(MLAT), .DIV_LAT(DLAT)) dut0 (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr), .instr_ready(b_ready),
    .stall_in(stall_in), .flush(flush), .valid_e(b_valid),
    .branch_e(b_br), .jump_e(b_jp), .jalr_e(b_jr), .mem_write_e(b_mw), .alu_src_e(b_as),
    .reg_write_e(b_rw), .result_src_e(b_rs), .imm_src_e(b_is), .alu_op_e(b_ao),
    .rs1_used_e(b_u1), .rs2_used_e(b_u2), .mul_en_e(b_mu), .div_en_e(b_dv),
    .illegal_e(b_il), .mdu_busy(b_busy), .mdu_done(b_done)
  );

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    else passed++;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic ctrl_t mk(input int br, jp, jr, mw, as, rw, rs, is, ao, u1, u2, mu, dv, il);
    ctrl_t c;
    c.branch = br[0]; c.jump = jp[0]; c.jalr = jr[0]; c.mem_write = mw[0];
    c.alu_src = as[0]; c.reg_write = rw[0]; c.result_src = rs[1:0]; c.imm_src = is[2:0];
    c.alu_op = ao[2:0]; c.rs1_used = u1[0]; c.rs2_used = u2[0]; c.mul_en = mu[0];
    c.div_en = dv[0]; c.illegal = il[0];
    return c;
  endfunction

  // Reference decode written from the opcode table.
  function automatic ctrl_t ref_decode(input logic [31:0] ins, input bit mext);
    logic [6:0] op;
    logic [6:0] f7;
    op = ins[6:0];
    f7 = ins[31:25];
    case (op)
      7'd51: begin
        if (f7 == 7'd0 || f7 == 7'd32) return mk(0,0,0,0,0,1, 0,0,2, 1,1,0,0,0);
        if (mext && f7 == 7'd1) begin
          if (ins[14]) return mk(0,0,0,0,0,1, 0,0,5, 1,1,0,1,0);
          return mk(0,0,0,0,0,1, 0,0,4, 1,1,1,0,0);
        end
        return mk(0,0,0,0,0,0, 0,0,0, 0,0,0,0,1);
      end
      7'd3:   return mk(0,0,0,0,1,1, 1,0,0, 1,0,0,0,0);
      7'd19:  return mk(0,0,0,0,1,1, 0,0,2, 1,0,0,0,0);
      7'd35:  return mk(0,0,0,1,1,0, 0,1,0, 1,1,0,0,0);
      7'd99:  return mk(1,0,0,0,0,0, 0,2,1, 1,1,0,0,0);
      7'd103: return mk(0,1,1,0,1,1, 2,0,0, 1,0,0,0,0);
      7'd111: return mk(0,1,0,0,0,1, 2,3,0, 0,0,0,0,0);
      7'd23:  return mk(0,0,0,0,0,1, 3,4,0, 0,0,0,0,0);
      7'd55:  return mk(0,0,0,0,1,1, 0,4,3, 0,0,0,0,0);
      default: return mk(0,0,0,0,0,0, 0,0,0, 0,0,0,0,1);
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    logic [6:0]  ops [12];
    logic [6:0]  f7s [5];
    ops = '{7'd51, 7'd3, 7'd19, 7'd35, 7'd99, 7'd103, 7'd111, 7'd23, 7'd55, 7'd51, 7'd51, 7'd0};
    f7s = '{7'd0, 7'd32, 7'd1, 7'd1, 7'd0};
    ins = $urandom;
    ins[6:0] = ops[$urandom_range(0, 11)];
    if (ins[6:0] == 7'd0) ins[6:0] = 7'($urandom);
    if ($urandom_range(0, 5) != 0) ins[31:25] = f7s[$urandom_range(0, 4)];
    return ins;
  endfunction

  vec_t  vecs [13];
  ctrl_t held;
  ctrl_t m_ctrl;
  bit    m_valid;
  int    m_left;
  bit    r_rst, r_fl, r_st, r_v, m_ready;

  initial begin
    vecs[0]  = '{32'h003100B3, mk(0,0,0,0,0,1, 0,0,2, 1,1,0,0,0)};
    vecs[1]  = '{32'h403100B3, mk(0,0,0,0,0,1, 0,0,2, 1,1,0,0,0)};
    vecs[2]  = '{32'h00812283, mk(0,0,0,0,1,1, 1,0,0, 1,0,0,0,0)};
    vecs[3]  = '{32'h00510093, mk(0,0,0,0,1,1, 0,0,2, 1,0,0,0,0)};
    vecs[4]  = '{32'h00512423, mk(0,0,0,1,1,0, 0,1,0, 1,1,0,0,0)};
    vecs[5]  = '{32'h00208463, mk(1,0,0,0,0,0, 0,2,1, 1,1,0,0,0)};
    vecs[6]  = '{32'h000080E7, mk(0,1,1,0,1,1, 2,0,0, 1,0,0,0,0)};
    vecs[7]  = '{32'h008000EF, mk(0,1,0,0,0,1, 2,3,0, 0,0,0,0,0)};
    vecs[8]  = '{32'h00001097, mk(0,0,0,0,0,1, 3,4,0, 0,0,0,0,0)};
    vecs[9]  = '{32'h000010B7, mk(0,0,0,0,1,1, 0,4,3, 0,0,0,0,0)};
    vecs[10] = '{32'h0000007F, mk(0,0,0,0,0,0, 0,0,0, 0,0,0,0,1)};
    vecs[11] = '{32'h043100B3, mk(0,0,0,0,0,0, 0,0,0, 0,0,0,0,1)};
    vecs[12] = '{32'h023100B3, mk(0,0,0,0,0,1, 0,0,4, 1,1,1,0,0)};

    // Reset state
    @(negedge clk);
    tick();
    chk("ready_in_reset", a_ready, 0);
    chk("reset_valid_e", a_valid, 0);
    chk("reset_ctrl", a_c, 0);
    chk("reset_busy", a_busy, 0);
    chk("reset_done", a_done, 0);
    rst = 1'b0;
    #1 chk("ready_after_reset", a_ready, 1);

    // Decode table
    for (int i = 0; i < 13; i++) begin
      instr_valid = 1'b0;
      tick();
      tick();
      instr = vecs[i].instr;
      instr_valid = 1'b1;
      #1 chk($sformatf("vec%0d_ready", i), a_ready, 1);
      tick();
      instr_valid = 1'b0;
      chk($sformatf("vec%0d_valid_e", i), a_valid, 1);
      chk($sformatf("vec%0d_ctrl", i), a_c, vecs[i].exp);
    end
    instr_valid = 1'b0;
    tick();
    tick();
    tick();

    // DIV timing, back-to-back add presented throughout
    instr = I_DIV;
    instr_valid = 1'b1;
    #1 chk("div_accept_ready", a_ready, 1);
    tick();
    instr = I_ADD;
    chk("div_en_e", a_dv, 1);
    chk("div_alu_op", a_ao, 5);
    for (int k = 1; k <= DLAT; k++) begin
      #1;
      chk($sformatf("div_busy_t%0d", k), a_busy, 1);
      chk($sformatf("div_done_t%0d", k), a_done, (k == DLAT) ? 1 : 0);
      chk($sformatf("div_ready_t%0d", k), a_ready, 0);
      chk($sformatf("div_valid_t%0d", k), a_valid, (k == 1) ? 1 : 0);
      chk($sformatf("div_hold_t%0d", k), a_dv, 1);
      tick();
    end
    #1;
    chk("div_end_busy", a_busy, 0);
    chk("div_end_done", a_done, 0);
    chk("div_end_ready", a_ready, 1);
    tick();
    instr_valid = 1'b0;
    chk("b2b_add_valid", a_valid, 1);
    chk("b2b_add_ctrl", a_c, mk(0,0,0,0,0,1, 0,0,2, 1,1,0,0,0));

    // DIV aborted by flush at t+10
    tick();
    instr = I_DIV;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    for (int k = 1; k < 10; k++) tick();
    chk("flush_pre_busy", a_busy, 1);
    flush = 1'b1;
    instr = I_ADD;
    instr_valid = 1'b1;
    #1 chk("flush_cycle_ready", a_ready, 0);
    tick();
    flush = 1'b0;
    instr_valid = 1'b0;
    #1;
    chk("flush_busy", a_busy, 0);
    chk("flush_valid_e", a_valid, 0);
    chk("flush_ready", a_ready, 1);
    begin
      int dones = 0;
      for (int k = 0; k < DLAT + 2; k++) begin
        if (a_done) dones++;
        tick();
      end
      chk("flush_no_done", dones, 0);
    end

    // Stall holds the e-stage, then an illegal opcode is accepted
    instr = I_ADD;
    instr_valid = 1'b1;
    tick();
    held = a_c;
    chk("stall_add_valid", a_valid, 1);
    instr = I_BAD;
    stall_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1 chk($sformatf("stall%0d_ready", k), a_ready, 0);
      tick();
      chk($sformatf("stall%0d_valid", k), a_valid, 1);
      chk($sformatf("stall%0d_ctrl", k), a_c, mk(0,0,0,0,0,1, 0,0,2, 1,1,0,0,0));
    end
    stall_in = 1'b0;
    #1 chk("unstall_ready", a_ready, 1);
    tick();
    instr_valid = 1'b0;
    chk("illegal_valid", a_valid, 1);
    chk("illegal_ctrl", a_c, mk(0,0,0,0,0,0, 0,0,0, 0,0,0,0,1));
    chk("stall_held_was_add", held, mk(0,0,0,0,0,1, 0,0,2, 1,1,0,0,0));

    // M_EXT=0 instance treats MUL as illegal
    rst = 1'b1;
    tick();
    rst = 1'b0;
    instr = I_MUL;
    instr_valid = 1'b1;
    #1 chk("m0_ready", b_ready, 1);
    tick();
    instr_valid = 1'b0;
    chk("m0_valid", b_valid, 1);
    chk("m0_ctrl", b_c, mk(0,0,0,0,0,0, 0,0,0, 0,0,0,0,1));
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("m0_busy%0d", k), b_busy, 0);
      chk($sformatf("m0_done%0d", k), b_done, 0);
      tick();
    end

    // Randomized run against the reference model (M_EXT=1 instance)
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_valid = 0;
    m_ctrl = '0;
    m_left = 0;
    for (int i = 0; i < 3000; i++) begin
      chk("rnd_valid_e", a_valid, m_valid);
      chk("rnd_busy", a_busy, (m_left > 0) ? 1 : 0);
      if (m_valid || m_left > 0) chk("rnd_ctrl", a_c, m_ctrl);
      r_rst = ($urandom_range(0, 99) < 2);
      r_fl  = ($urandom_range(0, 99) < 4);
      r_st  = ($urandom_range(0, 99) < 20);
      r_v   = ($urandom_range(0, 99) < 70);
      rst = r_rst;
      flush = r_fl;
      stall_in = r_st;
      instr_valid = r_v;
      instr = rand_instr();
      #1;
      m_ready = !r_rst && !r_fl && !r_st && (m_left == 0);
      chk("rnd_ready", a_ready, m_ready);
      chk("rnd_done", a_done, (m_left == 1 && !r_fl && !r_rst) ? 1 : 0);
      if (r_rst) begin
        m_valid = 0;
        m_ctrl = '0;
        m_left = 0;
      end else if (r_fl) begin
        m_valid = 0;
        m_left = 0;
      end else if (m_ready && r_v) begin
        m_valid = 1;
        m_ctrl = ref_decode(instr, 1'b1);
        m_left = m_ctrl.mul_en ? MLAT : (m_ctrl.div_en ? DLAT : 0);
      end else if (m_left > 0) begin
        m_left--;
        m_valid = 0;
      end else if (!r_st) begin
        m_valid = 0;
      end
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
